// File: rtl/lc3b_regfile_sb.sv
// lc3b_regfile_sb
//   Clocked register file for the pipelined LC-3b datapath.
//   NUM_REGS = 2**IDX_W registers of DATA_W bits. The file has two registered
//   read ports, one write port, a per-register busy scoreboard, and an NZP
//   condition-code register that is updated on writeback.
//
// Ports
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   rd_en, rd_index1/2     capture both read ports on this edge
//   rdata1/2, rd_busy1/2   registered read data and busy bits (latency 1)
//   wr_en, wr_index, wdata write port; wr_set_cc also loads cc_nzp from wdata
//   claim_en, claim_index  mark a register busy (a new producer has issued)
//   busy_vec               current scoreboard, bit i = register i pending
//   cc_nzp                 {N,Z,P}
//   claim_err              1-cycle pulse: claim of a busy register that is not
//                          written on the same edge
//
// Configuration
//   LC3B_REGFILE_BYPASS_EN  when defined, a read of wr_index on a write edge
//                           returns wdata. Otherwise the read returns the old value.
module lc3b_regfile_sb #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        rd_index1,
    input  logic [IDX_W-1:0]        rd_index2,
    output logic [DATA_W-1:0]       rdata1,
    output logic [DATA_W-1:0]       rdata2,
    output logic                    rd_busy1,
    output logic                    rd_busy2,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_index,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    wr_set_cc,
    input  logic                    claim_en,
    input  logic [IDX_W-1:0]        claim_index,
    output logic [(2**IDX_W)-1:0]   busy_vec,
    output logic [2:0]              cc_nzp,
    output logic                    claim_err
);

    localparam int NUM_REGS = 2**IDX_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [DATA_W-1:0]   rdata2_q, rdata2_d;
    logic                rd_busy1_q, rd_busy1_d;
    logic                rd_busy2_q, rd_busy2_d;
    logic [2:0]          cc_q, cc_d;
    logic                claim_err_q, claim_err_d;

    logic                claim_hits_write;

    always_comb begin
        regs_d      = regs_q;
        busy_d      = busy_q;
        rdata1_d    = rdata1_q;
        rdata2_d    = rdata2_q;
        rd_busy1_d  = rd_busy1_q;
        rd_busy2_d  = rd_busy2_q;
        cc_d        = cc_q;

        claim_hits_write = wr_en && (wr_index == claim_index);

        // Reads use pre-edge state. The bypass build overrides this for the written index.
        if (rd_en) begin
            rdata1_d   = regs_q[rd_index1];
            rdata2_d   = regs_q[rd_index2];
            rd_busy1_d = busy_q[rd_index1];
            rd_busy2_d = busy_q[rd_index2];
`ifdef LC3B_REGFILE_BYPASS_EN
            if (wr_en && (rd_index1 == wr_index)) begin
                rdata1_d   = wdata;
                rd_busy1_d = claim_en && (claim_index == wr_index);
            end
            if (wr_en && (rd_index2 == wr_index)) begin
                rdata2_d   = wdata;
                rd_busy2_d = claim_en && (claim_index == wr_index);
            end
`endif
        end

        if (wr_en) begin
            regs_d[wr_index] = wdata;
            busy_d[wr_index] = 1'b0;
            if (wr_set_cc) begin
                cc_d = {wdata[DATA_W-1], wdata == '0, ~wdata[DATA_W-1] & (|wdata)};
            end
        end

        // The claim is applied after the write clear, so a claim wins over a
        // same-edge write to the same index.
        if (claim_en) begin
            busy_d[claim_index] = 1'b1;
        end

        claim_err_d = claim_en && busy_q[claim_index] && !claim_hits_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q      <= '{default: '0};
            busy_q      <= '0;
            rdata1_q    <= '0;
            rdata2_q    <= '0;
            rd_busy1_q  <= 1'b0;
            rd_busy2_q  <= 1'b0;
            cc_q        <= 3'b010;
            claim_err_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            busy_q      <= busy_d;
            rdata1_q    <= rdata1_d;
            rdata2_q    <= rdata2_d;
            rd_busy1_q  <= rd_busy1_d;
            rd_busy2_q  <= rd_busy2_d;
            cc_q        <= cc_d;
            claim_err_q <= claim_err_d;
        end
    end

    assign rdata1    = rdata1_q;
    assign rdata2    = rdata2_q;
    assign rd_busy1  = rd_busy1_q;
    assign rd_busy2  = rd_busy2_q;
    assign busy_vec  = busy_q;
    assign cc_nzp    = cc_q;
    assign claim_err = claim_err_q;

endmodule
